// File: rtl/dcache_controller_if.sv
// dcache_controller_if: CPU-side and memory-side signal bundle for the data cache
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller: 32 x 256-bit direct-mapped write-back write-allocate data cache controller
module dcache_controller (
  input logic clk_i,
  input logic rst_i,
  dcache_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
  state_t state, next_state;
  logic [31:0] valid, dirty;
  logic [21:0] tag_mem [32];
  logic [255:0] data_mem [32];
  logic [26:0] lat_addr;
  logic [4:0] idx, lidx;
  logic [2:0] word;
  logic hit, miss, unused_bits;
  always_comb begin
    idx = bus.cpu_addr_i[9:5];
    word = bus.cpu_addr_i[4:2];
    lidx = lat_addr[4:0];
    hit = state == IDLE && bus.cpu_req_i && valid[idx] && tag_mem[idx] == bus.cpu_addr_i[31:10];
    miss = state == IDLE && bus.cpu_req_i && !hit;
    unused_bits = ^bus.cpu_addr_i[1:0];
  end
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (miss ? (valid[idx] && dirty[idx] ? WRITEBACK : FETCH) : IDLE) :
                 state == WRITEBACK ? (bus.mem_ack_i ? FETCH : WRITEBACK) :
                 (bus.mem_ack_i ? IDLE : FETCH);
  always_comb begin
    bus.cpu_data_o = hit && !bus.cpu_write_i ? data_mem[idx][{word, 5'd0} +: 32] : 32'd0;
    bus.cpu_stall_o = state != IDLE || miss;
    bus.mem_enable_o = state != IDLE;
    bus.mem_write_o = state == WRITEBACK;
    bus.mem_addr_o = state == WRITEBACK ? {tag_mem[lidx], lidx, 5'd0} :
                     state == FETCH ? {lat_addr, 5'd0} : 32'd0;
    bus.mem_data_o = state == WRITEBACK ? data_mem[lidx] : 256'd0;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (miss) lat_addr <= bus.cpu_addr_i[31:5];
      if (hit && bus.cpu_write_i) dirty[idx] <= 1'b1;
      if (state == FETCH && bus.mem_ack_i) begin
        valid[lidx] <= 1'b1;
        dirty[lidx] <= 1'b0;
      end
    end
  always_ff @(posedge clk_i)
    if (!rst_i && hit && bus.cpu_write_i) data_mem[idx][{word, 5'd0} +: 32] <= bus.cpu_data_i;
    else if (!rst_i && state == FETCH && bus.mem_ack_i) begin
      data_mem[lidx] <= bus.mem_data_i;
      tag_mem[lidx] <= lat_addr[26:5];
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for dcache_controller
module tb_dcache_controller;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int total = 0;
  int bad = 0;
  dcache_controller_if bus();
  dcache_controller dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'hC0DE_0000 | {16'd0, a[15:0] + 16'(w)};
    return r;
  endfunction
  task automatic cpu(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req_i = req;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = data;
    #1;
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic mem_cycle(input int delay, input logic [255:0] rdata, output logic [31:0] addr,
                           output logic wr, output logic [255:0] wdata, output logic stable, output logic timeout);
    int n = 0;
    timeout = 1'b0;
    stable = 1'b1;
    addr = '0;
    wr = 1'b0;
    wdata = '0;
    while (!bus.mem_enable_o && n < 50) begin
      step();
      n++;
    end
    if (!bus.mem_enable_o) begin
      timeout = 1'b1;
      return;
    end
    addr = bus.mem_addr_o;
    wr = bus.mem_write_o;
    wdata = bus.mem_data_o;
    for (int i = 0; i < delay; i++) begin
      step();
      if (bus.mem_addr_o !== addr || bus.mem_write_o !== wr || bus.mem_data_o !== wdata ||
          bus.mem_enable_o !== 1'b1 || bus.cpu_stall_o !== 1'b1) stable = 1'b0;
    end
    bus.mem_data_i = rdata;
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_hold_en got=%h want=0", bus.mem_enable_o); end
    rst_i = 1'b0;
    step();
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.cpu_data_o !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.cpu_data_o); end
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rst_en got=%h want=0", bus.mem_enable_o); end
    total++; if (bus.mem_write_o !== 1'b0) begin bad++; $display("FAIL rst_wr got=%h want=0", bus.mem_write_o); end
    total++; if (bus.mem_addr_o !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.mem_addr_o); end
    total++; if (bus.mem_data_o !== 256'd0) begin bad++; $display("FAIL rst_mdata got=%h want=0", bus.mem_data_o); end
  endtask
  task automatic test_cold_load();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    cpu(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    total++; if (bus.cpu_stall_o !== 1'b1) begin bad++; $display("FAIL cold_miss_stall got=%h want=1", bus.cpu_stall_o); end
    mem_cycle(3, pat(32'h40), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL cold_timeout got=%h want=0", t); end
    total++; if (a !== 32'h0000_0040) begin bad++; $display("FAIL cold_addr got=%h want=00000040", a); end
    total++; if (w !== 1'b0) begin bad++; $display("FAIL cold_wr got=%h want=0", w); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL cold_stable got=%h want=1", s); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL cold_hit_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_0040) begin bad++; $display("FAIL cold_data got=%h want=c0de0040", bus.cpu_data_o); end
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL cold_idle_en got=%h want=0", bus.mem_enable_o); end
  endtask
  task automatic test_store_load_hit();
    step();
    cpu(1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL st_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.cpu_data_o !== 32'd0) begin bad++; $display("FAIL st_data got=%h want=0", bus.cpu_data_o); end
    step();
    cpu(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    total++; if (bus.cpu_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_data got=%h want=deadbeef", bus.cpu_data_o); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL ld_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL ld_en got=%h want=0", bus.mem_enable_o); end
    step();
    cpu(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    total++; if (bus.cpu_data_o !== 32'hC0DE_0040) begin bad++; $display("FAIL ld_w0 got=%h want=c0de0040", bus.cpu_data_o); end
    step();
    cpu(1'b0, 1'b0, 32'h0000_0040, 32'd0);
    total++; if (bus.cpu_data_o !== 32'd0) begin bad++; $display("FAIL noreq_data got=%h want=0", bus.cpu_data_o); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL noreq_stall got=%h want=0", bus.cpu_stall_o); end
  endtask
  task automatic test_dirty_evict();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    step();
    cpu(1'b1, 1'b0, 32'h0000_0440, 32'd0);
    total++; if (bus.cpu_stall_o !== 1'b1) begin bad++; $display("FAIL de_stall got=%h want=1", bus.cpu_stall_o); end
    mem_cycle(2, pat(32'h440), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL de_wb_timeout got=%h want=0", t); end
    total++; if (w !== 1'b1) begin bad++; $display("FAIL de_wb_wr got=%h want=1", w); end
    total++; if (a !== 32'h0000_0040) begin bad++; $display("FAIL de_wb_addr got=%h want=00000040", a); end
    total++; if (d[63:32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL de_wb_w1 got=%h want=deadbeef", d[63:32]); end
    total++; if (d[31:0] !== 32'hC0DE_0040) begin bad++; $display("FAIL de_wb_w0 got=%h want=c0de0040", d[31:0]); end
    mem_cycle(1, pat(32'h440), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL de_fe_timeout got=%h want=0", t); end
    total++; if (w !== 1'b0) begin bad++; $display("FAIL de_fe_wr got=%h want=0", w); end
    total++; if (a !== 32'h0000_0440) begin bad++; $display("FAIL de_fe_addr got=%h want=00000440", a); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL de_hit_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_0440) begin bad++; $display("FAIL de_hit_data got=%h want=c0de0440", bus.cpu_data_o); end
  endtask
  task automatic test_clean_evict();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    step();
    cpu(1'b1, 1'b0, 32'h0000_0048, 32'd0);
    mem_cycle(2, pat(32'h40), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL ce_timeout got=%h want=0", t); end
    total++; if (w !== 1'b0 || s !== 1'b1) begin bad++; $display("FAIL ce_wr got=%h stable=%h want wr=0 stable=1", w, s); end
    total++; if (a !== 32'h0000_0040) begin bad++; $display("FAIL ce_addr got=%h want=00000040", a); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_0042) begin bad++; $display("FAIL ce_data got=%h want=c0de0042", bus.cpu_data_o); end
  endtask
  task automatic test_slow_mem();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    step();
    cpu(1'b1, 1'b1, 32'h0000_084C, 32'hCAFE_F00D);
    mem_cycle(20, pat(32'h840), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL sf_timeout got=%h want=0", t); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL sf_stable got=%h want=1", s); end
    total++; if (a !== 32'h0000_0840 || w !== 1'b0) begin bad++; $display("FAIL sf_addr got=%h wr=%h want=00000840 wr=0", a, w); end
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL sf_st_stall got=%h want=0", bus.cpu_stall_o); end
    step();
    cpu(1'b1, 1'b0, 32'h0000_084C, 32'd0);
    total++; if (bus.cpu_data_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL sf_ld got=%h want=cafef00d", bus.cpu_data_o); end
    step();
    cpu(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    mem_cycle(20, pat(32'h40), a, w, d, s, t);
    total++; if (t !== 1'b0) begin bad++; $display("FAIL sw_timeout got=%h want=0", t); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL sw_stable got=%h want=1", s); end
    total++; if (a !== 32'h0000_0840 || w !== 1'b1) begin bad++; $display("FAIL sw_addr got=%h wr=%h want=00000840 wr=1", a, w); end
    total++; if (d[127:96] !== 32'hCAFE_F00D) begin bad++; $display("FAIL sw_w3 got=%h want=cafef00d", d[127:96]); end
    total++; if (d[31:0] !== 32'hC0DE_0840) begin bad++; $display("FAIL sw_w0 got=%h want=c0de0840", d[31:0]); end
    mem_cycle(0, pat(32'h40), a, w, d, s, t);
    total++; if (a !== 32'h0000_0040 || t !== 1'b0) begin bad++; $display("FAIL sw_fe_addr got=%h timeout=%h want=00000040", a, t); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_0040) begin bad++; $display("FAIL sw_data got=%h want=c0de0040", bus.cpu_data_o); end
  endtask
  task automatic test_req_drop();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    step();
    cpu(1'b1, 1'b0, 32'h0000_1040, 32'd0);
    step();
    cpu(1'b0, 1'b0, 32'h0000_0000, 32'd0);
    mem_cycle(2, pat(32'h1040), a, w, d, s, t);
    total++; if (a !== 32'h0000_1040 || t !== 1'b0) begin bad++; $display("FAIL rd_addr got=%h timeout=%h want=00001040", a, t); end
    total++; if (bus.mem_enable_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL rd_idle got en=%h stall=%h want 0 0", bus.mem_enable_o, bus.cpu_stall_o); end
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    step();
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL idle_ack_en got=%h want=0", bus.mem_enable_o); end
    cpu(1'b1, 1'b0, 32'h0000_1040, 32'd0);
    total++; if (bus.cpu_stall_o !== 1'b0) begin bad++; $display("FAIL rd_hit_stall got=%h want=0", bus.cpu_stall_o); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_1040) begin bad++; $display("FAIL rd_hit_data got=%h want=c0de1040", bus.cpu_data_o); end
  endtask
  task automatic test_reset_mid_fetch();
    logic [31:0] a; logic w, s, t; logic [255:0] d;
    step();
    cpu(1'b1, 1'b0, 32'h0000_2040, 32'd0);
    step();
    total++; if (bus.mem_enable_o !== 1'b1) begin bad++; $display("FAIL rf_fetch_en got=%h want=1", bus.mem_enable_o); end
    rst_i = 1'b1;
    bus.mem_data_i = pat(32'h2040);
    bus.mem_ack_i = 1'b1;
    cpu(1'b0, 1'b0, 32'h0000_2040, 32'd0);
    step();
    rst_i = 1'b0;
    bus.mem_ack_i = 1'b0;
    total++; if (bus.mem_enable_o !== 1'b0) begin bad++; $display("FAIL rf_en got=%h want=0", bus.mem_enable_o); end
    step();
    cpu(1'b1, 1'b0, 32'h0000_2040, 32'd0);
    total++; if (bus.cpu_stall_o !== 1'b1) begin bad++; $display("FAIL rf_remiss got=%h want=1", bus.cpu_stall_o); end
    mem_cycle(1, pat(32'h2040), a, w, d, s, t);
    total++; if (a !== 32'h0000_2040 || w !== 1'b0 || t !== 1'b0) begin bad++; $display("FAIL rf_refetch got=%h wr=%h timeout=%h want=00002040 wr=0", a, w, t); end
    total++; if (bus.cpu_data_o !== 32'hC0DE_2040) begin bad++; $display("FAIL rf_data got=%h want=c0de2040", bus.cpu_data_o); end
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
  endtask
  initial begin
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    cpu(1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_cold_load();
    test_store_load_hit();
    test_dirty_evict();
    test_clean_evict();
    test_slow_mem();
    test_req_drop();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
